// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with a one-word output
// holding register, consumer handshake and sticky overrun flag.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sdi,
  input  logic             sdi_en,
  input  logic             clear,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_next, q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovr_q, ovr_d, acc, done;
  always_comb begin
    acc     = sdi_en & ~clear;
    done    = acc && (cnt_q == CW'(WIDTH - 1));
    sr_next = MSB_FIRST ? {sr_q[WIDTH-2:0], sdi} : {sdi, sr_q[WIDTH-1:1]};
    sr_d    = clear ? '0 : acc ? sr_next : sr_q;
    cnt_d   = clear ? '0 : !acc ? cnt_q : done ? '0 : cnt_q + 1'b1;
    // A completion loads q when the register is empty or being drained this edge.
    q_d     = (done && (state_q == EMPTY || q_ready)) ? sr_next : q_q;
    ovr_d   = clear ? 1'b0 : ovr_q | (done && state_q == FULL && !q_ready);
    state_d = clear ? EMPTY : done ? FULL : (state_q == FULL && q_ready) ? EMPTY : state_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      sr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      ovr_q   <= ovr_d;
    end
  end
  assign q       = q_q;
  assign q_valid = (state_q == FULL);
  assign bit_cnt = cnt_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed checks of sipo_deser with MSB-first and LSB-first
// instances driven by the same serial stream.
module tb_sipo_deser;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic       sdi = 1'b0, sdi_en = 1'b0, clear = 1'b0, q_ready = 1'b0;
  logic [3:0] q0, q1;
  logic       v0, v1, o0, o1;
  logic [2:0] c0, c1;
  int         cmp = 0, mis = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .reset_n(reset_n), .sdi(sdi), .sdi_en(sdi_en), .clear(clear),
    .q_ready(q_ready), .q(q0), .q_valid(v0), .bit_cnt(c0), .overrun(o0));
  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .reset_n(reset_n), .sdi(sdi), .sdi_en(sdi_en), .clear(clear),
    .q_ready(q_ready), .q(q1), .q_valid(v1), .bit_cnt(c1), .overrun(o1));

  // Inputs change on the falling edge; the task returns one falling edge later.
  task automatic step(input logic en, input logic d, input logic rdy, input logic clr);
    sdi_en = en; sdi = d; q_ready = rdy; clear = clr;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    cmp++; if ({q0, v0, c0, o0} !== 9'b0) begin mis++; $display("FAIL reset_u0 got q=%b v=%b cnt=%0d ovr=%b want 0", q0, v0, c0, o0); end
    cmp++; if ({q1, v1, c1, o1} !== 9'b0) begin mis++; $display("FAIL reset_u1 got q=%b v=%b cnt=%0d ovr=%b want 0", q1, v1, c1, o1); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_msb_first;
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    cmp++; if ({q0, v0, c0, o0} !== {4'b0101, 1'b1, 3'd0, 1'b0}) begin mis++; $display("FAIL msb_word got q=%b v=%b cnt=%0d ovr=%b want 0101 1 0 0", q0, v0, c0, o0); end
    cmp++; if ({q1, v1} !== {4'b1010, 1'b1}) begin mis++; $display("FAIL lsb_word got q=%b v=%b want 1010 1", q1, v1); end
    step(0, 0, 0, 1);
  endtask

  task automatic test_overrun;
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    cmp++; if ({q0, v0, o0} !== {4'b0101, 1'b1, 1'b0}) begin mis++; $display("FAIL ovr_first got q=%b v=%b ovr=%b want 0101 1 0", q0, v0, o0); end
    repeat (4) step(1, 1, 0, 0);
    cmp++; if ({q0, v0, o0} !== {4'b0101, 1'b1, 1'b1}) begin mis++; $display("FAIL ovr_set got q=%b v=%b ovr=%b want 0101 1 1", q0, v0, o0); end
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    cmp++; if (o0 !== 1'b1) begin mis++; $display("FAIL ovr_sticky got %b want 1", o0); end
    step(0, 0, 0, 1);
    cmp++; if ({q0, v0, o0} !== {4'b0101, 1'b0, 1'b0}) begin mis++; $display("FAIL ovr_clear got q=%b v=%b ovr=%b want 0101 0 0", q0, v0, o0); end
  endtask

  task automatic test_gaps;
    logic [3:0] bits;
    bits = 4'b1010;
    repeat (4) step(1, 1, 0, 0);
    cmp++; if ({q1, v1} !== {4'b1111, 1'b1}) begin mis++; $display("FAIL gap_pre got q=%b v=%b want 1111 1", q1, v1); end
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, bits[i], 0, 0);
      if (i < 3)
        for (int g = 0; g < 2; g++) begin
          step(0, 1, 0, 0);
          cmp++; if (c1 !== 3'(i + 1)) begin mis++; $display("FAIL gap_cnt%0d got %0d want %0d", i, c1, i + 1); end
        end
    end
    cmp++; if ({q1, v1, c1} !== {4'b1010, 1'b1, 3'd0}) begin mis++; $display("FAIL gap_word got q=%b v=%b cnt=%0d want 1010 1 0", q1, v1, c1); end
    step(0, 0, 0, 1);
  endtask

  task automatic test_back_to_back;
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 0, 1, 0);
    cmp++; if ({q0, v0, o0} !== {4'b1100, 1'b1, 1'b0}) begin mis++; $display("FAIL b2b_reload got q=%b v=%b ovr=%b want 1100 1 0", q0, v0, o0); end
    step(0, 0, 1, 0);
    cmp++; if ({q0, v0} !== {4'b1100, 1'b0}) begin mis++; $display("FAIL b2b_drain got q=%b v=%b want 1100 0", q0, v0); end
    step(0, 0, 1, 0);
    cmp++; if ({q0, v0, o0} !== {4'b1100, 1'b0, 1'b0}) begin mis++; $display("FAIL ready_empty got q=%b v=%b ovr=%b want 1100 0 0", q0, v0, o0); end
  endtask

  task automatic test_reset_mid;
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(0, 0, 0, 0);
    cmp++; if (c0 !== 3'd2) begin mis++; $display("FAIL rst_pre got cnt=%0d want 2", c0); end
    #1 reset_n = 1'b0;
    #1;
    cmp++; if ({c0, q0, v0} !== 8'b0) begin mis++; $display("FAIL rst_async got cnt=%0d q=%b v=%b want 0", c0, q0, v0); end
    #1 reset_n = 1'b1;
    @(negedge clk);
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    cmp++; if ({q0, v0, c0} !== {4'b0011, 1'b1, 3'd0}) begin mis++; $display("FAIL rst_word got q=%b v=%b cnt=%0d want 0011 1 0", q0, v0, c0); end
    step(0, 0, 0, 1);
  endtask

  task automatic test_clear_bit;
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    cmp++; if (c0 !== 3'd3) begin mis++; $display("FAIL clr_pre got cnt=%0d want 3", c0); end
    step(1, 1, 0, 1);
    cmp++; if ({c0, v0} !== {3'd0, 1'b0}) begin mis++; $display("FAIL clr_bit got cnt=%0d v=%b want 0 0", c0, v0); end
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    cmp++; if ({c0, v0} !== {3'd3, 1'b0}) begin mis++; $display("FAIL clr_restart got cnt=%0d v=%b want 3 0", c0, v0); end
    step(1, 1, 0, 0);
    cmp++; if ({q0, v0} !== {4'b1001, 1'b1}) begin mis++; $display("FAIL clr_word got q=%b v=%b want 1001 1", q0, v0); end
  endtask

  initial begin
    test_reset;
    test_msb_first;
    test_overrun;
    test_gaps;
    test_back_to_back;
    test_reset_mid;
    test_clear_bit;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
